// File: rtl/trap_request_unit_if.sv
// ----------------------------------------------------------------------------
// trap_request_unit_if
// Handshake between the pipeline-side trap requester and the machine CSR file.
//   trap_sources  : 1-cycle trap request pulse           (requester -> CSR)
//   trap_instr_pc : PC of the trapping instruction       (requester -> CSR)
//   trap_cause    : zero-extended exception cause        (requester -> CSR)
//   is_mret       : 1-cycle MRET request pulse           (requester -> CSR)
//   flush_trap    : ack, trap taken, next_pc valid       (CSR -> requester)
//   csr_update_pc : ack, MRET taken, next_pc valid       (CSR -> requester)
//   next_pc       : redirect target (mtvec or mepc)      (CSR -> requester)
// Modports: master = requester side, slave = CSR side.
// ----------------------------------------------------------------------------
interface trap_request_unit_if;
    logic        trap_sources;
    logic [31:0] trap_instr_pc;
    logic [31:0] trap_cause;
    logic        is_mret;
    logic        flush_trap;
    logic        csr_update_pc;
    logic [31:0] next_pc;

    modport master (
        output trap_sources, trap_instr_pc, trap_cause, is_mret,
        input  flush_trap, csr_update_pc, next_pc
    );

    modport slave (
        input  trap_sources, trap_instr_pc, trap_cause, is_mret,
        output flush_trap, csr_update_pc, next_pc
    );
endinterface

// File: rtl/trap_request_unit.sv
// ----------------------------------------------------------------------------
// trap_request_unit
// Pipeline-side initiator for the CSR trap/return interface. Picks the oldest
// pending exception (or an MRET), pulses the request to the CSR file, waits
// for its acknowledge, then redirects fetch and flushes the pipeline.
//
// Ports:
//   clk, reset       : clock (rising edge), asynchronous active-high reset
//   src_valid        : per-stage exception request (index NSRC-1 = oldest)
//   src_pc/src_cause : flattened per-source PC (32b) and cause (5b)
//   mret_req         : MRET reached EX
//   csr              : CSR handshake interface (master modport)
//   irq_in/irq_out   : external interrupt, gated off while a trap is in flight
//   stall, flush     : pipeline freeze / kill
//   redirect_valid   : 1-cycle load of redirect_pc into the PC
//   redirect_pc      : captured CSR target
//   err_timeout      : sticky, CSR never acknowledged (cleared only by reset)
//
// Build option: define TRAP_IRQ_SYNC_EN to pass irq_in through a 2-flop
// synchronizer before gating; otherwise irq_out is combinational.
// ----------------------------------------------------------------------------
module trap_request_unit #(
    parameter int NSRC         = 4,
    parameter int ACK_TIMEOUT  = 8,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NSRC-1:0]      src_valid,
    input  logic [32*NSRC-1:0]   src_pc,
    input  logic [5*NSRC-1:0]    src_cause,
    input  logic                 mret_req,
    trap_request_unit_if.master  csr,
    input  logic                 irq_in,
    output logic                 irq_out,
    output logic                 stall,
    output logic                 flush,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc,
    output logic                 err_timeout
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_WAIT     = 3'd2,
        ST_REDIRECT = 3'd3,
        ST_DRAIN    = 3'd4
    } state_t;

    localparam logic [7:0] ACK_LAST   = 8'(ACK_TIMEOUT - 1);
    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

    state_t      state_r;
    logic [7:0]  cnt_r;        // shared by WAIT (ack timeout) and DRAIN
    logic        kind_trap_r;  // 1 = trap in flight, 0 = MRET in flight
    logic        any_src_s;
    logic [31:0] sel_pc_s;
    logic [4:0]  sel_cause_s;
    logic        ack_s;

    assign any_src_s = |src_valid;
    // Only the acknowledge matching the request kind counts.
    assign ack_s     = kind_trap_r ? csr.flush_trap : csr.csr_update_pc;

    // Oldest-source select: ascending scan, so the highest set index wins.
    always_comb begin
        sel_pc_s    = 32'd0;
        sel_cause_s = 5'd0;
        for (int i = 0; i < NSRC; i++) begin
            if (src_valid[i]) begin
                sel_pc_s    = src_pc[32*i +: 32];
                sel_cause_s = src_cause[5*i +: 5];
            end else begin
                sel_pc_s    = sel_pc_s;
                sel_cause_s = sel_cause_s;
            end
        end
    end

    // Request FSM with all handshake and pipeline-control outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r           <= ST_IDLE;
            cnt_r             <= 8'd0;
            kind_trap_r       <= 1'b0;
            csr.trap_sources  <= 1'b0;
            csr.trap_instr_pc <= 32'd0;
            csr.trap_cause    <= 32'd0;
            csr.is_mret       <= 1'b0;
            stall             <= 1'b0;
            flush             <= 1'b0;
            redirect_valid    <= 1'b0;
            redirect_pc       <= 32'd0;
            err_timeout       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // An exception always beats a simultaneous MRET; the MRET
                    // instruction is younger and gets flushed.
                    if (any_src_s) begin
                        state_r           <= ST_ISSUE;
                        kind_trap_r       <= 1'b1;
                        csr.trap_instr_pc <= sel_pc_s;
                        csr.trap_cause    <= {27'd0, sel_cause_s};
                        csr.trap_sources  <= 1'b1;
                        stall             <= 1'b1;
                    end else if (mret_req) begin
                        state_r     <= ST_ISSUE;
                        kind_trap_r <= 1'b0;
                        csr.is_mret <= 1'b1;
                        stall       <= 1'b1;
                    end else begin
                        stall <= 1'b0;
                        flush <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    csr.trap_sources <= 1'b0;
                    csr.is_mret      <= 1'b0;
                    cnt_r            <= 8'd0;
                    state_r          <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Ack is checked first so an ack on the final cycle wins.
                    if (ack_s) begin
                        redirect_pc    <= csr.next_pc;
                        redirect_valid <= 1'b1;
                        flush          <= 1'b1;
                        cnt_r          <= 8'd0;
                        state_r        <= ST_REDIRECT;
                    end else if (cnt_r == ACK_LAST) begin
                        err_timeout <= 1'b1;
                        flush       <= 1'b1;
                        cnt_r       <= 8'd0;
                        state_r     <= ST_DRAIN;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_REDIRECT: begin
                    redirect_valid <= 1'b0;
                    cnt_r          <= 8'd0;
                    state_r        <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (cnt_r == DRAIN_LAST) begin
                        flush   <= 1'b0;
                        stall   <= 1'b0;
                        cnt_r   <= 8'd0;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r          <= ST_IDLE;
                    cnt_r            <= 8'd0;
                    csr.trap_sources <= 1'b0;
                    csr.is_mret      <= 1'b0;
                    redirect_valid   <= 1'b0;
                    flush            <= 1'b0;
                    stall            <= 1'b0;
                end
            endcase
        end
    end

`ifdef TRAP_IRQ_SYNC_EN
    logic irq_meta_r;
    logic irq_sync_r;

    // Two-flop synchronizer for the asynchronous external interrupt line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_meta_r <= 1'b0;
            irq_sync_r <= 1'b0;
        end else begin
            irq_meta_r <= irq_in;
            irq_sync_r <= irq_meta_r;
        end
    end

    // Interrupts are hidden while a trap or MRET is in flight.
    assign irq_out = irq_sync_r & (state_r == ST_IDLE);
`else
    // Interrupts are hidden while a trap or MRET is in flight; reset masks
    // the raw line so every output reads 0 during reset.
    assign irq_out = irq_in & (state_r == ST_IDLE) & ~reset;
`endif

endmodule

// File: tb/tb_trap_request_unit.sv
// ----------------------------------------------------------------------------
// tb_trap_request_unit
// Scoreboard bench: expected CSR pulses and redirects are queued as stimulus
// is issued; a negedge monitor pops and compares whenever the DUT presents
// trap_sources, is_mret or redirect_valid. Timing-specific properties (flush
// length, timeout instant, reset, irq gating) are checked inline.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_trap_request_unit;

    localparam int NSRC        = 4;
    localparam int ACK_TIMEOUT = 8;

    localparam int K_TRAP  = 0;
    localparam int K_MRET  = 1;
    localparam int K_REDIR = 2;

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    logic                clk;
    logic                reset;
    logic [NSRC-1:0]     src_valid;
    logic [32*NSRC-1:0]  src_pc;
    logic [5*NSRC-1:0]   src_cause;
    logic                mret_req;
    logic                irq_in;
    logic                irq_out;
    logic                stall;
    logic                flush;
    logic                redirect_valid;
    logic [31:0]         redirect_pc;
    logic                err_timeout;

    trap_request_unit_if csr_if();

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    trap_request_unit #(.NSRC(NSRC), .ACK_TIMEOUT(ACK_TIMEOUT), .DRAIN_CYCLES(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .src_valid      (src_valid),
        .src_pc         (src_pc),
        .src_cause      (src_cause),
        .mret_req       (mret_req),
        .csr            (csr_if),
        .irq_in         (irq_in),
        .irq_out        (irq_out),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .err_timeout    (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.kind = kind;
        e.a    = a;
        e.b    = b;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every DUT-presented pulse against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (csr_if.trap_sources) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL trap_pulse: got unexpected trap pc=0x%08h expected no pulse", csr_if.trap_instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != K_TRAP || csr_if.trap_instr_pc !== e.a ||
                        csr_if.trap_cause !== e.b || stall !== 1'b1 || csr_if.is_mret !== 1'b0) begin
                        errors++;
                        $display("FAIL trap_pulse: got pc=0x%08h cause=0x%08h stall=%0b expected kind=%0d pc=0x%08h cause=0x%08h stall=1",
                                 csr_if.trap_instr_pc, csr_if.trap_cause, stall, e.kind, e.a, e.b);
                    end
                end
            end
            if (csr_if.is_mret) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL mret_pulse: got unexpected is_mret expected no pulse");
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != K_MRET || stall !== 1'b1) begin
                        errors++;
                        $display("FAIL mret_pulse: got is_mret stall=%0b expected kind=%0d stall=1", stall, e.kind);
                    end
                end
            end
            if (redirect_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL redirect: got unexpected redirect pc=0x%08h expected none", redirect_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != K_REDIR || redirect_pc !== e.a || flush !== 1'b1 || stall !== 1'b1) begin
                        errors++;
                        $display("FAIL redirect: got pc=0x%08h flush=%0b stall=%0b expected kind=%0d pc=0x%08h flush=1 stall=1",
                                 redirect_pc, flush, stall, e.kind, e.a);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int idx, input logic [31:0] pc, input logic [4:0] cause);
        src_pc[32*idx +: 32]  = pc;
        src_cause[5*idx +: 5] = cause;
    endtask

    // Present a request for one sampling edge; on return the DUT is in ISSUE.
    task automatic issue_req(input logic [NSRC-1:0] sv, input logic mret);
        src_valid = sv;
        mret_req  = mret;
        tick();
        src_valid = '0;
        mret_req  = 1'b0;
    endtask

    // From ISSUE: enter WAIT, idle 'delay' cycles, then ack for one cycle.
    task automatic do_ack(input logic is_trap, input logic [31:0] npc, input int delay);
        tick();
        repeat (delay) tick();
        csr_if.flush_trap    = is_trap;
        csr_if.csr_update_pc = ~is_trap;
        csr_if.next_pc       = npc;
        tick();
        csr_if.flush_trap    = 1'b0;
        csr_if.csr_update_pc = 1'b0;
    endtask

    // Count flush cycles until stall drops, bounded.
    task automatic wait_idle(input int exp_flush, input string name);
        int n    = 0;
        bit done = 1'b0;
        for (int k = 0; k < 30 && !done; k++) begin
            @(negedge clk);
            if (flush) n++;
            if (!stall) done = 1'b1;
        end
        chk({name, "_back_idle"}, 32'(done), 32'd1);
        chk({name, "_flush_cycles"}, 32'(n), 32'(exp_flush));
    endtask

    initial begin
        reset                = 1'b1;
        src_valid            = '0;
        src_pc               = '0;
        src_cause            = '0;
        mret_req             = 1'b0;
        irq_in               = 1'b0;
        csr_if.flush_trap    = 1'b0;
        csr_if.csr_update_pc = 1'b0;
        csr_if.next_pc       = 32'd0;

        // Reset state
        @(negedge clk);
        chk("reset_outputs", {22'd0, csr_if.trap_sources, csr_if.is_mret, stall, flush,
                              redirect_valid, err_timeout, irq_out, 3'd0}, 32'd0);
        chk("reset_trap_pc", csr_if.trap_instr_pc, 32'd0);
        chk("reset_redirect_pc", redirect_pc, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // 1: single source, ack next cycle
        set_src(1, 32'h0000_0100, 5'd2);
        push(K_TRAP, 32'h0000_0100, 32'h0000_0002);
        push(K_REDIR, 32'h0000_0080, 32'd0);
        issue_req(4'b0010, 1'b0);
        do_ack(1'b1, 32'h0000_0080, 0);
        wait_idle(3, "t1");

        // 2: oldest source wins
        set_src(3, 32'h0000_0200, 5'd6);
        set_src(1, 32'h0000_010C, 5'd3);
        push(K_TRAP, 32'h0000_0200, 32'h0000_0006);
        push(K_REDIR, 32'h0000_0303, 32'd0);
        tick();
        issue_req(4'b1010, 1'b0);
        do_ack(1'b1, 32'h0000_0303, 1);
        wait_idle(3, "t2");

        // 3a: exception beats simultaneous MRET
        set_src(0, 32'h0000_0400, 5'd11);
        push(K_TRAP, 32'h0000_0400, 32'h0000_000B);
        push(K_REDIR, 32'h0000_0500, 32'd0);
        issue_req(4'b0001, 1'b1);
        do_ack(1'b1, 32'h0000_0500, 0);
        wait_idle(3, "t3a");

        // 3b: MRET alone; a stray flush_trap must not complete it
        push(K_MRET, 32'd0, 32'd0);
        push(K_REDIR, 32'h0000_0104, 32'd0);
        issue_req(4'b0000, 1'b1);
        tick();
        csr_if.flush_trap = 1'b1;
        csr_if.next_pc    = 32'hDEAD_BEEF;
        tick();
        csr_if.flush_trap    = 1'b0;
        csr_if.csr_update_pc = 1'b1;
        csr_if.next_pc       = 32'h0000_0104;
        tick();
        csr_if.csr_update_pc = 1'b0;
        wait_idle(3, "t3b");

        // 4: no ack -> timeout exactly ACK_TIMEOUT cycles after WAIT entry
        set_src(2, 32'h0000_0600, 5'd7);
        push(K_TRAP, 32'h0000_0600, 32'h0000_0007);
        issue_req(4'b0100, 1'b0);
        tick();
        for (int j = 0; j < ACK_TIMEOUT; j++) begin
            @(negedge clk);
            chk("t4_err_before_timeout", {31'd0, err_timeout}, 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("t4_err_at_timeout", {29'd0, err_timeout, flush, redirect_valid}, 32'h6);
        tick();
        wait_idle(1, "t4");
        chk("t4_err_sticky", {31'd0, err_timeout}, 32'd1);

        // 4b: ack on the final WAIT cycle wins over timeout
        set_src(0, 32'h0000_0700, 5'd1);
        push(K_TRAP, 32'h0000_0700, 32'h0000_0001);
        push(K_REDIR, 32'h0000_0701, 32'd0);
        issue_req(4'b0001, 1'b0);
        do_ack(1'b1, 32'h0000_0701, ACK_TIMEOUT - 1);
        wait_idle(3, "t4b");

        // 5: asynchronous reset while in WAIT
        set_src(0, 32'h0000_0800, 5'd5);
        push(K_TRAP, 32'h0000_0800, 32'h0000_0005);
        issue_req(4'b0001, 1'b0);
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("t5_reset_ctrl", {24'd0, csr_if.trap_sources, csr_if.is_mret, stall, flush,
                              redirect_valid, err_timeout, irq_out, 1'b0}, 32'd0);
        chk("t5_reset_cause", csr_if.trap_cause, 32'd0);
        chk("t5_reset_trap_pc", csr_if.trap_instr_pc, 32'd0);
        chk("t5_reset_redirect_pc", redirect_pc, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        set_src(3, 32'h0000_0900, 5'd4);
        push(K_TRAP, 32'h0000_0900, 32'h0000_0004);
        push(K_REDIR, 32'h0000_0084, 32'd0);
        issue_req(4'b1000, 1'b0);
        do_ack(1'b1, 32'h0000_0084, 0);
        wait_idle(3, "t5_after");

        // 6: interrupt gating
        tick();
        irq_in = 1'b1;
`ifdef TRAP_IRQ_SYNC_EN
        @(negedge clk);
        chk("t6_irq_sync_0", {31'd0, irq_out}, 32'd0);
        @(negedge clk);
        chk("t6_irq_sync_1", {31'd0, irq_out}, 32'd0);
        @(negedge clk);
        chk("t6_irq_sync_2", {31'd0, irq_out}, 32'd1);
`else
        @(negedge clk);
        chk("t6_irq_idle", {31'd0, irq_out}, 32'd1);
`endif
        @(posedge clk);
        #1;
        set_src(0, 32'h0000_0A00, 5'd9);
        push(K_TRAP, 32'h0000_0A00, 32'h0000_0009);
        push(K_REDIR, 32'h0000_0A80, 32'd0);
        issue_req(4'b0001, 1'b0);
        @(negedge clk);
        chk("t6_irq_issue", {31'd0, irq_out}, 32'd0);
        @(posedge clk);
        #0;
        csr_if.flush_trap = 1'b1;
        csr_if.next_pc    = 32'h0000_0A80;
        #1;
        tick();
        csr_if.flush_trap = 1'b0;
        tick();
        @(negedge clk);
        chk("t6_irq_drain", {30'd0, irq_out, flush}, 32'd1);
        tick();
        wait_idle(1, "t6");
        chk("t6_irq_back_idle", {31'd0, irq_out}, 32'd1);
        irq_in = 1'b0;
        #1;
`ifndef TRAP_IRQ_SYNC_EN
        chk("t6_irq_low", {31'd0, irq_out}, 32'd0);
`endif

        tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
